// File: rtl/mul_node_sched.sv
// mul_node_sched: round-robin scheduler that shares one serial FP32 product engine
// among NUM_REQ requesters. One job is in flight at a time. The granted requester's
// operands are buffered locally, then streamed to the engine using its ack-pulse
// handshake. The product is returned tagged with the requester id.
module mul_node_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [3*NUM_REQ-1:0]    req_cnt,
  input  logic [NUM_REQ-1:0]      op_valid,
  input  logic [32*NUM_REQ-1:0]   op_data,
  output logic [NUM_REQ-1:0]      op_ready,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    m_stb,
  input  logic                    m_ack,
  output logic [31:0]             m_data,
  output logic [2:0]              m_cnt_max,
  input  logic                    m_z_stb,
  input  logic [31:0]             m_z,
  output logic                    m_z_ack,
  output logic                    res_valid,
  output logic [31:0]             res_data,
  output logic [ID_W-1:0]         res_id,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_ISSUE,
    S_WAIT_Z,
    S_RESP
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          ld_idx_q, ld_idx_d;
  logic [2:0]          is_idx_q, is_idx_d;
  logic                err_cnt_q, err_cnt_d;
  logic                res_valid_q, res_valid_d;
  logic [31:0]         res_data_q, res_data_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;
  logic [31:0]         op_buf_q [8];
  logic [31:0]         op_buf_d [8];

  logic                arb_found;
  logic [ID_W-1:0]     arb_pick;
  logic [ID_W-1:0]     arb_cand;
  logic [2:0]          pick_cnt;
  logic                sel_op_valid;
  logic [31:0]         sel_op_data;

  // Round-robin search: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_cand  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!arb_found && (arb_cand == ID_W'(i)) && req_valid[i]) begin
          arb_found = 1'b1;
          arb_pick  = ID_W'(i);
        end
      end
      arb_cand = (arb_cand == LAST_ID) ? '0 : arb_cand + ID_W'(1);
    end
  end

  // Per-requester muxes: job size of the arbitration winner, operand of the owner.
  always_comb begin
    pick_cnt     = '0;
    sel_op_valid = 1'b0;
    sel_op_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_pick == ID_W'(i)) begin
        pick_cnt = req_cnt[3*i +: 3];
      end
      if (id_q == ID_W'(i)) begin
        sel_op_valid = op_valid[i];
        sel_op_data  = op_data[32*i +: 32];
      end
    end
  end

  // Next-state and datapath updates for the job sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    ld_idx_d    = ld_idx_q;
    is_idx_d    = is_idx_q;
    err_cnt_d   = err_cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    op_buf_d    = op_buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          id_d = arb_pick;
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (arb_pick == ID_W'(i));
          // A zero-length job would give the engine nothing to multiply; run it as one multiply.
          if (pick_cnt == 3'd0) begin
            cnt_d     = 3'd1;
            err_cnt_d = 1'b1;
          end else begin
            cnt_d = pick_cnt;
          end
          rr_ptr_d = (arb_pick == LAST_ID) ? '0 : arb_pick + ID_W'(1);
          ld_idx_d = '0;
          state_d  = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (sel_op_valid) begin
          op_buf_d[ld_idx_q] = sel_op_data;
          if (ld_idx_q == cnt_q) begin
            is_idx_d = '0;
            state_d  = S_ISSUE;
          end else begin
            ld_idx_d = ld_idx_q + 3'd1;
          end
        end
      end
      S_ISSUE: begin
        if (m_ack) begin
          if (is_idx_q == cnt_q) state_d = S_WAIT_Z;
          else is_idx_d = is_idx_q + 3'd1;
        end
      end
      S_WAIT_Z: begin
        if (m_z_stb) begin
          res_data_d  = m_z;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          grant_d     = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      ld_idx_q    <= '0;
      is_idx_q    <= '0;
      err_cnt_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      ld_idx_q    <= ld_idx_d;
      is_idx_q    <= is_idx_d;
      err_cnt_q   <= err_cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  // Operand buffer has no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    op_buf_q <= op_buf_d;
  end

  // Output decode from the current state.
  always_comb begin
    op_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_ready[i] = (state_q == S_LOAD) && (id_q == ID_W'(i));
    end
    m_stb     = (state_q == S_ISSUE);
    m_data    = (state_q == S_ISSUE) ? op_buf_q[is_idx_q] : 32'd0;
    m_cnt_max = cnt_q;
    m_z_ack   = (state_q == S_WAIT_Z);
    busy      = (state_q != S_IDLE);
    grant     = grant_q;
    res_valid = res_valid_q;
    res_data  = res_data_q;
    res_id    = res_id_q;
    err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_mul_node_sched.sv
// Testbench for mul_node_sched. The requester driver, engine model, scoreboard
// monitor and directed stimulus each run in their own process.
module tb_mul_node_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [3*NUM_REQ-1:0]  req_cnt;
  logic [NUM_REQ-1:0]    op_valid;
  logic [32*NUM_REQ-1:0] op_data;
  logic [NUM_REQ-1:0]    op_ready;
  logic [NUM_REQ-1:0]    grant;
  logic                  m_stb;
  logic                  m_ack;
  logic [31:0]           m_data;
  logic [2:0]            m_cnt_max;
  logic                  m_z_stb;
  logic [31:0]           m_z;
  logic                  m_z_ack;
  logic                  res_valid;
  logic [31:0]           res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_ready;
  logic                  busy;
  logic                  err_cnt;

  mul_node_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cnt(req_cnt),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .grant(grant),
    .m_stb(m_stb), .m_ack(m_ack), .m_data(m_data), .m_cnt_max(m_cnt_max),
    .m_z_stb(m_z_stb), .m_z(m_z), .m_z_ack(m_z_ack),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
  } exp_t;
  exp_t sb_q[$];

  // Requester-side job storage: word ring plus job-size ring per requester.
  logic [31:0] words [NUM_REQ][64];
  int          jcnt  [NUM_REQ][16];
  int          wtail [NUM_REQ] = '{default: 0};
  int          whead [NUM_REQ] = '{default: 0};
  int          jtail [NUM_REQ] = '{default: 0};
  int          jhead [NUM_REQ] = '{default: 0};
  int          loaded[NUM_REQ] = '{default: 0};
  int          consumed[NUM_REQ] = '{default: 0};
  int          gap_ctr[NUM_REQ] = '{default: 0};
  bit          sent  [NUM_REQ] = '{default: 0};
  bit          gap_mode[NUM_REQ] = '{default: 0};

  int          ack_total = 0;
  logic [31:0] eng_ops [8];

  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic int job_words(input int c);
    return (c == 0) ? 2 : c + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Requester driver: presents operands of the front job, pops words on accept.
  initial begin
    req_valid = '0;
    req_cnt   = '0;
    op_valid  = '0;
    op_data   = '0;
    forever begin
      @(posedge clk); #3;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!rst) begin
          whead[r]  = wtail[r];
          jhead[r]  = jtail[r];
          loaded[r] = 0;
          sent[r]   = 1'b0;
        end else if (sent[r]) begin
          whead[r]++;
          loaded[r]++;
          consumed[r]++;
          sent[r] = 1'b0;
          if (loaded[r] == job_words(jcnt[r][jhead[r] % 16])) begin
            jhead[r]++;
            loaded[r] = 0;
          end
        end
        gap_ctr[r] = (gap_ctr[r] == 2) ? 0 : gap_ctr[r] + 1;
        if (jhead[r] != jtail[r]) begin
          req_valid[r]         = 1'b1;
          req_cnt[3*r +: 3]    = 3'(jcnt[r][jhead[r] % 16]);
          op_data[32*r +: 32]  = words[r][whead[r] % 64];
          op_valid[r]          = !gap_mode[r] || (gap_ctr[r] == 0);
        end else begin
          req_valid[r]         = 1'b0;
          req_cnt[3*r +: 3]    = 3'd0;
          op_data[32*r +: 32]  = 32'd0;
          op_valid[r]          = 1'b0;
        end
        sent[r] = op_valid[r] && op_ready[r];
      end
    end
  end

  // Engine model: ack pulse per operand, fixed latency, then result strobe until acked.
  initial begin
    real prod;
    int  n_ops;
    int  lat;
    bit  collecting;
    bit  zhs;
    m_ack = 1'b0; m_z_stb = 1'b0; m_z = 32'd0;
    prod = 1.0; n_ops = 0; lat = 0; collecting = 1'b1; zhs = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        m_ack = 1'b0; m_z_stb = 1'b0; m_z = 32'd0;
        prod = 1.0; n_ops = 0; lat = 0; collecting = 1'b1; zhs = 1'b0;
      end else begin
        if (zhs) begin
          m_z_stb = 1'b0; zhs = 1'b0; collecting = 1'b1; n_ops = 0; prod = 1.0;
        end
        if (m_ack) begin
          m_ack = 1'b0;
        end else if (collecting && m_stb) begin
          m_ack = 1'b1;
          ack_total++;
          eng_ops[n_ops % 8] = m_data;
          prod = prod * fp2r(m_data);
          n_ops++;
          if (n_ops == int'(m_cnt_max) + 1) begin
            collecting = 1'b0;
            lat = 3;
          end
        end else if (!collecting && !m_z_stb) begin
          if (lat == 0) begin
            m_z_stb = 1'b1;
            m_z = r2fp(prod);
          end else begin
            lat--;
          end
        end
        if (m_z_stb && m_z_ack) zhs = 1'b1;
      end
    end
  end

  // Result monitor: pops the scoreboard on each new result and checks it while held.
  initial begin
    exp_t cur;
    bit   active;
    bit   bad;
    active = 1'b0;
    bad    = 1'b0;
    cur    = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        active = 1'b0;
      end else begin
        checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        if (res_valid) begin
          if (!active) begin
            active = 1'b1;
            if (sb_q.size() == 0) begin
              n_checks++;
              n_fails++;
              bad = 1'b1;
              $display("[TB] FAIL unexpected_result: got data 0x%08h id %0d, expected no result", res_data, res_id);
            end else begin
              bad = 1'b0;
              cur = sb_q.pop_front();
            end
          end
          if (!bad) begin
            checkOutput("res_data", res_data, cur.data);
            checkOutput("res_id", 32'(res_id), 32'(cur.id));
            checkOutput("grant_owner", 32'(grant), 32'(1 << cur.id));
          end
        end else begin
          active = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int r, input int cnt, input int nw,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input bit expect_res, input logic [31:0] exp_data);
    logic [31:0] ws [4];
    exp_t e;
    ws = '{w0, w1, w2, w3};
    for (int i = 0; i < nw; i++) begin
      words[r][wtail[r] % 64] = ws[i];
      wtail[r]++;
    end
    jcnt[r][jtail[r] % 16] = cnt;
    jtail[r]++;
    if (expect_res) begin
      e.data = exp_data;
      e.id   = ID_W'(r);
      sb_q.push_back(e);
    end
  endtask

  task automatic waitIdle(input string name, input int budget);
    int c;
    c = 0;
    while ((sb_q.size() != 0 || busy || (|req_valid)) && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= budget) begin
      n_fails++;
      $display("[TB] FAIL %s: timeout after %0d cycles, expected scheduler idle with all results seen", name, c);
    end
  endtask

  task automatic waitFor(input string name, input int which, input int budget);
    int c;
    bit hit;
    c = 0;
    hit = 1'b0;
    while (!hit && c < budget) begin
      @(negedge clk);
      c++;
      case (which)
        0: hit = grant[0];
        1: hit = res_valid;
        default: hit = m_stb;
      endcase
    end
    n_checks++;
    if (!hit) begin
      n_fails++;
      $display("[TB] FAIL %s: event not seen within %0d cycles, expected it", name, budget);
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Directed test sequence.
  initial begin
    int a0;
    int c0;
    bit stable;
    logic [31:0] held_data;
    logic [ID_W-1:0] held_id;
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_res_data", res_data, 32'd0);
    checkOutput("reset_op_ready", 32'(op_ready), 32'd0);
    checkOutput("reset_m_stb", 32'(m_stb), 32'd0);
    checkOutput("reset_m_z_ack", 32'(m_z_ack), 32'd0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] T1 req0 2.0*3.0");
    a0 = ack_total;
    applyStimulus(0, 1, 2, 32'h40000000, 32'h40400000, 0, 0, 1'b1, 32'h40C00000);
    waitIdle("t1_done", 300);
    checkOutput("t1_ack_pulses", 32'(ack_total - a0), 32'd2);
    checkOutput("t1_err_cnt", 32'(err_cnt), 32'd0);

    $display("[TB] T2 req2 four operands of 2.0");
    a0 = ack_total;
    applyStimulus(2, 3, 4, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 1'b1, 32'h41800000);
    waitIdle("t2_done", 300);
    checkOutput("t2_ack_pulses", 32'(ack_total - a0), 32'd4);

    $display("[TB] T3 all requesters pending, round-robin order");
    doReset();
    applyStimulus(0, 1, 2, 32'h3F800000, 32'h40000000, 0, 0, 1'b1, 32'h40000000);
    applyStimulus(1, 1, 2, 32'h40000000, 32'h40000000, 0, 0, 1'b1, 32'h40800000);
    applyStimulus(2, 1, 2, 32'h40400000, 32'h40000000, 0, 0, 1'b1, 32'h40C00000);
    applyStimulus(3, 1, 2, 32'h40800000, 32'h40000000, 0, 0, 1'b1, 32'h41000000);
    applyStimulus(0, 1, 2, 32'h40400000, 32'h40400000, 0, 0, 1'b1, 32'h41100000);
    waitIdle("t3_done", 800);

    $display("[TB] T4 result backpressure");
    res_ready = 1'b0;
    applyStimulus(0, 1, 2, 32'h3F800000, 32'h40400000, 0, 0, 1'b1, 32'h40400000);
    waitFor("t4_grant0", 0, 100);
    applyStimulus(1, 1, 2, 32'h40000000, 32'h40000000, 0, 0, 1'b1, 32'h40800000);
    waitFor("t4_res_valid", 1, 200);
    held_data = res_data;
    held_id   = res_id;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (res_data !== held_data || res_id !== held_id || grant !== 4'b0001 || !res_valid) stable = 1'b0;
    end
    checkOutput("t4_held_stable", 32'(stable), 32'd1);
    checkOutput("t4_req1_pending", 32'(req_valid[1]), 32'd1);
    res_ready = 1'b1;
    waitIdle("t4_done", 400);

    $display("[TB] T5 req1 operand gaps");
    gap_mode[1] = 1'b1;
    applyStimulus(1, 2, 3, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 1'b1, 32'h40C00000);
    waitIdle("t5_done", 400);
    gap_mode[1] = 1'b0;
    checkOutput("t5_op0", eng_ops[0], 32'h3F800000);
    checkOutput("t5_op1", eng_ops[1], 32'h40000000);
    checkOutput("t5_op2", eng_ops[2], 32'h40400000);

    $display("[TB] T6 reset during issue, rerun, zero-count job");
    applyStimulus(0, 1, 2, 32'h40000000, 32'h40400000, 0, 0, 1'b0, 32'h0);
    waitFor("t6_issue", 2, 100);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_grant", 32'(grant), 32'd0);
    checkOutput("t6_res_valid", 32'(res_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1, 2, 32'h40000000, 32'h40400000, 0, 0, 1'b1, 32'h40C00000);
    waitIdle("t6_rerun", 300);
    checkOutput("t6_err_before", 32'(err_cnt), 32'd0);
    c0 = consumed[3];
    applyStimulus(3, 0, 2, 32'h40000000, 32'h40400000, 0, 0, 1'b1, 32'h40C00000);
    waitIdle("t6_zero_cnt", 300);
    checkOutput("t6_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("t6_ops_consumed", 32'(consumed[3] - c0), 32'd2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
